// File: rtl/pc_branch_unit.sv
// Next-PC register with conditional/unconditional branches, call/return
// through a circular return-address stack, and a pipeline stall hold.
module pc_branch_unit #(
  parameter int              PC_W      = 32,
  parameter int              DATA_W    = 32,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  localparam int             PTR_W     = $clog2(RAS_DEPTH),
  localparam int             CNT_W     = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [DATA_W-1:0] cond_data,
  input  logic [2:0]        branch_op,
  input  logic [PC_W-1:0]   target_in,
  output logic [PC_W-1:0]   pc_out,
  output logic              taken,
  output logic [CNT_W-1:0]  ras_count,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_JUMP = 3'b001,
    OP_CALL = 3'b010,
    OP_BLTZ = 3'b011,
    OP_RET  = 3'b100,
    OP_BGTZ = 3'b101,
    OP_BNEZ = 3'b110,
    OP_BEQZ = 3'b111
  } op_e;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             taken_q, taken_d;
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [PC_W-1:0]  mem_q [RAS_DEPTH];

  op_e              op;
  logic [PC_W-1:0]  seq_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic             c_neg;
  logic             c_zero;
  logic             push;

  assign op     = op_e'(branch_op);
  assign seq_pc = pc_in + PC_W'(1);
  assign rd_ptr = wp_q - PTR_W'(1);
  assign c_neg  = cond_data[DATA_W-1];
  assign c_zero = (cond_data == '0);

  always_comb begin
    pc_d    = pc_q;
    taken_d = taken_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (!stall) begin
      pc_d    = seq_pc;
      taken_d = 1'b0;
      unique case (op)
        OP_JUMP: begin
          pc_d    = target_in;
          taken_d = 1'b1;
        end
        OP_CALL: begin
          pc_d    = target_in;
          taken_d = 1'b1;
          push    = 1'b1;
          wp_d    = wp_q + PTR_W'(1);
          // A full stack overwrites its oldest slot, which is the one at wp.
          if (cnt_q == FULL) ovf_d = 1'b1;
          else               cnt_d = cnt_q + CNT_W'(1);
        end
        OP_RET: begin
          if (cnt_q != '0) begin
            pc_d    = mem_q[rd_ptr];
            taken_d = 1'b1;
            wp_d    = rd_ptr;
            cnt_d   = cnt_q - CNT_W'(1);
          end else begin
            unf_d = 1'b1;
          end
        end
        OP_BLTZ: begin
          if (c_neg) begin
            pc_d    = target_in;
            taken_d = 1'b1;
          end
        end
        OP_BGTZ: begin
          if (!c_neg && !c_zero) begin
            pc_d    = target_in;
            taken_d = 1'b1;
          end
        end
        OP_BNEZ: begin
          if (!c_zero) begin
            pc_d    = target_in;
            taken_d = 1'b1;
          end
        end
        OP_BEQZ: begin
          if (c_zero) begin
            pc_d    = target_in;
            taken_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      wp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wp_q] <= seq_pc;
  end

  assign pc_out        = pc_q;
  assign taken         = taken_q;
  assign ras_count     = cnt_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: queue-based reference model, per-cycle
// comparison, literal pins for the directed scenarios, then random traffic.
module tb_pc_branch_unit;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] pc_in;
  logic [31:0] cond_data;
  logic [2:0]  branch_op;
  logic [31:0] target_in;
  logic [31:0] pc_out;
  logic        taken;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  pc_branch_unit #(
    .PC_W(32), .DATA_W(32), .RAS_DEPTH(D), .RESET_PC(32'd0)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .pc_in(pc_in), .cond_data(cond_data),
    .branch_op(branch_op), .target_in(target_in),
    .pc_out(pc_out), .taken(taken), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] ras[$];
  logic [31:0] m_pc;
  bit          m_tk, m_ov, m_un;

  // expectation visible to the compare process
  logic [31:0] e_pc;
  bit          e_tk, e_ov, e_un;
  int          e_cnt;
  bit          chk_en = 1'b0;

  // literal pins
  int          pin_id = 0;
  int          pin_seen = 0;
  logic [31:0] p_pc;
  bit          p_tk, p_ov, p_un;
  int          p_cnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc_out, e_pc);
      chk("taken", {31'd0, taken}, {31'd0, e_tk});
      chk("count", {29'd0, ras_count}, e_cnt);
      chk("ovf", {31'd0, ras_overflow}, {31'd0, e_ov});
      chk("unf", {31'd0, ras_underflow}, {31'd0, e_un});
      if (pin_id != pin_seen) begin
        chk("pin_pc", pc_out, p_pc);
        chk("pin_taken", {31'd0, taken}, {31'd0, p_tk});
        chk("pin_count", {29'd0, ras_count}, p_cnt);
        chk("pin_ovf", {31'd0, ras_overflow}, {31'd0, p_ov});
        chk("pin_unf", {31'd0, ras_underflow}, {31'd0, p_un});
        pin_seen = pin_id;
      end
    end
  end

  task automatic model(input bit rs, input bit st, input logic [2:0] op,
                       input logic [31:0] pc, input logic [31:0] cd,
                       input logic [31:0] tg);
    logic signed [31:0] c;
    logic [31:0]        nx;
    bit                 go;
    c  = cd;
    nx = pc + 32'd1;
    if (rs) begin
      m_pc = 32'd0; m_tk = 0; m_ov = 0; m_un = 0;
      ras.delete();
    end else if (!st) begin
      go = 0;
      case (op)
        3'd1: go = 1;
        3'd3: go = (c < 0);
        3'd5: go = (c > 0);
        3'd6: go = (c != 0);
        3'd7: go = (c == 0);
        default: go = 0;
      endcase
      m_pc = go ? tg : nx;
      m_tk = go;
      if (op == 3'd2) begin
        ras.push_back(nx);
        if (ras.size() > D) begin
          void'(ras.pop_front());
          m_ov = 1;
        end
        m_pc = tg; m_tk = 1;
      end else if (op == 3'd4) begin
        if (ras.size() > 0) begin
          m_pc = ras.pop_back(); m_tk = 1;
        end else begin
          m_un = 1;
        end
      end
    end
  endtask

  task automatic cycle(input bit rs, input bit st, input logic [2:0] op,
                       input logic [31:0] pc, input logic [31:0] cd,
                       input logic [31:0] tg);
    reset = rs; stall = st; branch_op = op;
    pc_in = pc; cond_data = cd; target_in = tg;
    model(rs, st, op, pc, cd, tg);
    @(posedge clk);
    e_pc = m_pc; e_tk = m_tk; e_ov = m_ov; e_un = m_un;
    e_cnt = ras.size();
    chk_en = 1'b1;
    #1;
  endtask

  task automatic pin(input logic [31:0] pc, input bit tk, input int cnt,
                     input bit ov, input bit un);
    p_pc = pc; p_tk = tk; p_cnt = cnt; p_ov = ov; p_un = un;
    pin_id++;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] rcd, rpc;
    reset = 1; stall = 0; branch_op = 0;
    pc_in = 0; cond_data = 0; target_in = 0;

    // reset beats a jump
    cycle(1, 0, 3'd1, 32'd3, 32'd0, 32'd50);  pin(0, 0, 0, 0, 0);

    // conditions with cond_data = -3
    cycle(0, 0, 3'd3, 32'd10, -32'sd3, 32'd40); pin(40, 1, 0, 0, 0);
    cycle(0, 0, 3'd5, 32'd10, -32'sd3, 32'd40); pin(11, 0, 0, 0, 0);
    cycle(0, 0, 3'd6, 32'd10, -32'sd3, 32'd40); pin(40, 1, 0, 0, 0);
    cycle(0, 0, 3'd7, 32'd10, -32'sd3, 32'd40); pin(11, 0, 0, 0, 0);
    cycle(0, 0, 3'd7, 32'd10, 32'd0, 32'd40);   pin(40, 1, 0, 0, 0);

    // nested call/return
    cycle(0, 0, 3'd2, 32'd5, 32'd0, 32'd20);  pin(20, 1, 1, 0, 0);
    cycle(0, 0, 3'd2, 32'd22, 32'd0, 32'd30); pin(30, 1, 2, 0, 0);
    cycle(0, 0, 3'd4, 32'd31, 32'd0, 32'd77); pin(23, 1, 1, 0, 0);
    cycle(0, 0, 3'd4, 32'd24, 32'd0, 32'd77); pin(6, 1, 0, 0, 0);

    // overflow then underflow
    for (int i = 1; i <= 5; i++) begin
      cycle(0, 0, 3'd2, i, 32'd0, 32'd100 + i);
      pin(100 + i, 1, (i > 4) ? 4 : i, i == 5, 0);
    end
    cycle(0, 0, 3'd4, 32'd60, 32'd0, 32'd9); pin(6, 1, 3, 1, 0);
    cycle(0, 0, 3'd4, 32'd60, 32'd0, 32'd9); pin(5, 1, 2, 1, 0);
    cycle(0, 0, 3'd4, 32'd60, 32'd0, 32'd9); pin(4, 1, 1, 1, 0);
    cycle(0, 0, 3'd4, 32'd60, 32'd0, 32'd9); pin(3, 1, 0, 1, 0);
    cycle(0, 0, 3'd4, 32'd50, 32'd0, 32'd9); pin(51, 0, 0, 1, 1);

    // stall holds a call
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 3'd2, 32'd70, 32'd0, 32'd99); pin(51, 0, 0, 1, 1);
    end
    cycle(0, 0, 3'd0, 32'd7, 32'd0, 32'd99); pin(8, 0, 0, 1, 1);

    // wrap, then reset mid-sequence
    cycle(0, 0, 3'd0, 32'hFFFF_FFFF, 32'd0, 32'd5); pin(0, 0, 0, 1, 1);
    cycle(0, 0, 3'd2, 32'd9, 32'd0, 32'd12);        pin(12, 1, 1, 1, 1);
    cycle(1, 0, 3'd2, 32'd9, 32'd0, 32'd12);        pin(0, 0, 0, 0, 0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: rcd = 32'd0;
        1: rcd = 32'hFFFF_FFFF;
        2: rcd = 32'd1;
        default: rcd = $urandom;
      endcase
      rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0,
            rop, rpc, rcd, $urandom);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Parametrised next-PC register for the single-cycle datapath, replacing the fixed 32-bit branch/PC update.
- Evaluates conditional and unconditional branches, CALL/RETURN through an internal circular return-address stack (RAS), and a pipeline stall hold.
- Sits between the ALU (target address) and the instruction memory address port; the PC is word-addressed, so sequential flow is +1.

Parameters:
- PC_W, 32, width of the PC, target and return addresses.
- DATA_W, 32, width of the condition operand (signed).
- RAS_DEPTH, 4, number of return-address entries; power of two, at least 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; takes effect on the rising edge of clk.
- stall  in  1  holds all state when 1.
- pc_in  in  PC_W  current instruction PC.
- cond_data  in  DATA_W  signed operand for the condition test.
- branch_op  in  3  operation code (encoding below).
- target_in  in  PC_W  branch/call target from the ALU.
- pc_out  out  PC_W  registered next PC.
- taken  out  1  registered; 1 when the last update redirected the PC.
- ras_count  out  clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ras_overflow  out  1  sticky; set when a CALL discards the oldest entry.
- ras_underflow  out  1  sticky; set when a RETURN finds the RAS empty.

Behaviour:
- branch_op encoding:
  - 000 none
  - 001 jump
  - 010 call
  - 011 branch if cond_data<0
  - 100 return
  - 101 branch if cond_data>0
  - 110 branch if cond_data!=0
  - 111 branch if cond_data==0
- Priority per edge: reset > stall > branch_op.
- Reset:
  - pc_out=RESET_PC, taken=0, ras_count=0, both flags=0.
  - RAS write pointer=0; RAS contents are don't-care.
  - Reset overrides stall and any in-flight op.
- Stall=1: pc_out, taken, RAS pointer, count and flags all hold; branch_op is ignored (a CALL does not push).
- Sequential (op 000, or a false condition):
  - pc_out<=pc_in+1, taken<=0.
  - Addition is modulo 2^PC_W, so all-ones wraps to 0.
- Jump, or a true condition: pc_out<=target_in, taken<=1.
- Conditions compare cond_data as a DATA_W-bit two's-complement value.
- CALL:
  - pc_out<=target_in, taken<=1.
  - mem[wp]<=pc_in+1 (modulo), wp<=wp+1 mod RAS_DEPTH.
  - If count<RAS_DEPTH: count+1.
  - If count==RAS_DEPTH: count holds, the oldest entry is overwritten, ras_overflow<=1.
- RETURN with count>0:
  - pc_out<=mem[wp-1 mod RAS_DEPTH], taken<=1.
  - wp<=wp-1, count-1.
  - target_in is ignored.
- RETURN with count==0:
  - pc_out<=pc_in+1, taken<=0, ras_underflow<=1.
  - Pointer and count are unchanged.
- Latency: one cycle; all outputs are registered, with no combinational path from inputs to outputs.
- Sticky flags clear only on reset.

Test Plan:
- Reset: assert reset 1 cycle with RESET_PC=0 and op=001, target=50 -> pc_out=0, taken=0, ras_count=0, flags=0.
- Conditions: pc_in=10, target=40, cond_data=-3 with op 011/101/110/111 in turn -> pc_out 40/11/40/11 and taken 1/0/1/0; cond_data=0 with op 111 -> pc_out=40.
- Call/return nesting: CALL at pc_in 5 (target 20), CALL at pc_in 22 (target 30), RETURN, RETURN -> pc_out 20, 30, 23, 6; ras_count 1, 2, 1, 0.
- Overflow, RAS_DEPTH=4: five CALLs from pc_in 1..5 then five RETURNs -> returns yield 6, 5, 4, 3, then underflow (pc_in+1, taken=0); ras_overflow=1 after the 5th CALL, ras_underflow=1 after the 5th RETURN.
- Stall: stall=1 with CALL and target=99 for 3 cycles -> pc_out, ras_count and taken unchanged; release with op=000, pc_in=7 -> pc_out=8.
- Wrap and reset mid-sequence: pc_in=all-ones, op=000 -> pc_out=0; then CALL followed by reset -> ras_count=0, pc_out=RESET_PC, flags cleared.
